ram_port_arb: RTL and testbench
===============================

Name: ram_port_arb

Overview:
- Shares one frame-buffer port of the 4-port RAM interface (wr/rd enable, ready, address, data, rd_data_valid) between NUM_REQ requesters, e.g. two capture writers and one readout engine.
- Arbitration is round-robin, one command per grant.
- Each read is tagged with its requester's index so that returned read data is routed back to the requester that issued it.
- Sits between the frame-buffer address generators and the RAM interface, one instance per RAM port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AW, 24, address width.
- DW, 32, data width.
- RD_DEPTH, 8, maximum outstanding reads, i.e. tag FIFO depth (power of 2).

Ports:
- clk  in  1  single clock for the block and the RAM-port user side.
- reset  in  1  asynchronous, active-low reset.
- req_wr  in  NUM_REQ  per-requester write request (level).
- req_rd  in  NUM_REQ  per-requester read request (level).
- req_addr  in  NUM_REQ*AW  flattened per-requester address; slice i = [i*AW +: AW].
- req_wr_data  in  NUM_REQ*DW  flattened per-requester write data.
- grant  out  NUM_REQ  one-hot, 1-cycle pulse in the cycle the command is issued.
- grant_is_rd  out  1  qualifies grant: 1 = read issued, 0 = write issued.
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse when returned read data belongs to requester i.
- rsp_data  out  DW  returned read data, valid with rsp_valid.
- wr_en, rd_en  out  1  RAM port command strobes.
- wr_addr, rd_addr  out  AW  RAM port addresses.
- wr_data  out  DW  RAM port write data.
- wr_rdy, rd_rdy  in  1  RAM port ready.
- rd_data_valid  in  1  RAM read-return strobe: 1-cycle high pulse per word, synchronous to clk.
- rd_data  in  DW  RAM read data.
- rsp_err  out  1  sticky: rd_data_valid arrived while the tag FIFO was empty.

Behaviour:
- Reset values:
  - All outputs 0; rsp_err = 0.
  - State = ARB; tag FIFO empty.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
- States:
  - ARB:
    - Eligible(i) = req_wr[i] OR (req_rd[i] AND tag FIFO not full).
    - Winner = first eligible index searching last+1, last+2, ... modulo NUM_REQ.
    - If a winner exists: register winner, op (write if req_wr[i], else read), address and data; go to ISSUE.
    - Otherwise stay in ARB.
  - ISSUE (write op):
    - wr_en = wr_rdy; wr_addr and wr_data from the registered copies.
    - In the cycle wr_rdy = 1: grant[winner] = 1, grant_is_rd = 0, last <= winner, next state ARB.
    - While the relevant ready is low: hold ISSUE, keep registered values stable, no grant.
  - ISSUE (read op): the same rule using rd_en, rd_rdy and rd_addr, with grant_is_rd = 1; additionally push winner onto the tag FIFO in the cycle rd_rdy = 1.
- Latency: request visible at cycle N gives its earliest strobe/grant at N+1. Maximum throughput is one command per 2 cycles.
- Requester rules:
  - A requester must hold req_* stable until its grant.
  - It must drop or advance req_* in the cycle after grant, otherwise it re-arbitrates (a new command, not an error).
- wr/rd priority: write has priority over read within one requester. The read is served on that requester's next win.
- Returns:
  - On rd_data_valid: pop the tag FIFO; rsp_valid[tag] = 1 and rsp_data = rd_data, both registered, so they appear 1 cycle after rd_data_valid.
  - Returns are strictly in issue order.
- Simultaneous push and pop in one cycle are both performed; the count is unchanged.
- Tag FIFO full (RD_DEPTH outstanding): reads are ineligible, writes proceed normally.
- rd_data_valid with the FIFO empty: set rsp_err, no rsp_valid, no pointer change. rsp_err clears only on reset.
- Reset asserted mid-operation: immediate clear of all state, the FIFO and outstanding tags. Data returned after reset is flagged through rsp_err.
- wr_en and rd_en are never asserted in the same cycle. Each is asserted only when its ready is 1.

Decomposition:
- Shared package contents:
  - State encoding ARB/ISSUE.
  - Function for the tag width, clog2(NUM_REQ).
  - `ASSERT_L/DEASSERT_L macros, as already used across the design.
- Sub-module tag_fifo: synchronous FIFO, width = tag width, depth = RD_DEPTH; provides push, pop, full, empty, dout.
- Round-robin selection stays inline in ram_port_arb.

Test Plan:
- Single writer: req_wr[0]=1, addr 0x000010, data 0xFFFFFF, wr_rdy=1 -> wr_en for one cycle at N+1 with wr_addr 0x000010, wr_data 0x00FFFFFF, grant=4'b0001, grant_is_rd=0.
- Fairness: all four req_wr held high for 16 grants -> grant sequence 0,1,2,3,0,1,2,3...; each requester gets exactly 4 grants.
- Read routing: requester 2 reads addr 7, then requester 1 reads addr 8; the RAM returns 0xA, then 0xB, 5 cycles later -> rsp_valid=4'b0100 with 0xA, then 4'b0010 with 0xB, each 1 cycle after its rd_data_valid.
- Backpressure and FIFO full:
  - rd_rdy=0 for 10 cycles -> rd_en stays 0, grant stays 0, rd_addr stable; the grant occurs in the cycle rd_rdy rises.
  - 8 outstanding reads with no return -> a ninth read is not granted while a concurrent req_wr[3] is granted.
- Error and reset: rd_data_valid pulse with an empty FIFO -> rsp_err=1 and rsp_valid=0. Reset asserted during ISSUE -> all outputs 0 within the same cycle; the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/ram_port_arb_pkg.sv
// ram_port_arb_pkg: shared state encoding, tag-width helper and reset-level macros
`ifndef RAM_PORT_ARB_PKG_SV
`define RAM_PORT_ARB_PKG_SV
`define ASSERT_L 1'b0
`define DEASSERT_L 1'b1
package ram_port_arb_pkg;
  typedef enum logic {ARB = 1'b0, ISSUE = 1'b1} state_e;
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage
`endif

// File: rtl/ram_port_arb_tag_fifo.sv
// tag_fifo: synchronous FIFO holding requester tags of outstanding reads
// Ports: clk/reset (async, active-low), push/din write side, pop/dout read side,
//        full/empty status. Push while full and pop while empty are ignored.
module tag_fifo
  import ram_port_arb_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int PW = $clog2(DEPTH);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]  wp_q, wp_d, rp_q, rp_d;
  logic [W-1:0] mem_q [DEPTH];
  always_comb begin
    full  = (wp_q ^ rp_q) == {1'b1, {PW{1'b0}}};
    empty = wp_q == rp_q;
    dout  = mem_q[rp_q[PW-1:0]];
    wp_d  = wp_q + {{PW{1'b0}}, push && !full};
    rp_d  = rp_q + {{PW{1'b0}}, pop && !empty};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (reset == `ASSERT_L) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wp_q[PW-1:0]] <= din;
  end
endmodule

// File: rtl/ram_port_arb.sv
// ram_port_arb: round-robin sharing of one RAM port between NUM_REQ requesters
// Ports: req_wr/req_rd/req_addr/req_wr_data per-requester commands (flattened);
//        grant/grant_is_rd issue pulse; rsp_valid/rsp_data routed read returns;
//        wr_en/rd_en/wr_addr/rd_addr/wr_data, wr_rdy/rd_rdy, rd_data_valid/rd_data
//        RAM port side; rsp_err sticky flag for a return with no outstanding read.
module ram_port_arb
  import ram_port_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int AW       = 24,
  parameter int DW       = 32,
  parameter int RD_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ-1:0]    req_rd,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  grant_is_rd,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [AW-1:0]         wr_addr,
  output logic [AW-1:0]         rd_addr,
  output logic [DW-1:0]         wr_data,
  input  logic                  wr_rdy,
  input  logic                  rd_rdy,
  input  logic                  rd_data_valid,
  input  logic [DW-1:0]         rd_data,
  output logic                  rsp_err
);
  localparam int TW = tag_w(NUM_REQ);
  state_e               state_q, state_d;
  logic [TW-1:0]        win_q, win_d, last_q, last_d, sel, hi, lo, tag;
  logic                 op_rd_q, op_rd_d, op_rd_sel, hi_f, lo_f, issue, rdy;
  logic                 push, pop, full, empty, err_q, err_d;
  logic [AW-1:0]        addr_q, addr_d, addr_sel;
  logic [DW-1:0]        data_q, data_d, data_sel, rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]   elig, rsp_valid_q, rsp_valid_d;
  always_comb begin
    elig = req_wr | (req_rd & {NUM_REQ{!full}});
    hi   = '0;
    lo   = '0;
    hi_f = 1'b0;
    lo_f = 1'b0;
    // Descending scan leaves the lowest eligible index overall (lo) and the
    // lowest one above last (hi); hi wins when present, giving the rotation.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo   = TW'(i);
        lo_f = 1'b1;
        if (i > int'(last_q)) begin
          hi   = TW'(i);
          hi_f = 1'b1;
        end
      end
    end
    sel       = hi_f ? hi : lo;
    addr_sel  = '0;
    data_sel  = '0;
    op_rd_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (TW'(i) == sel) begin
        addr_sel  = req_addr[i*AW +: AW];
        data_sel  = req_wr_data[i*DW +: DW];
        op_rd_sel = !req_wr[i];
      end
    end
    issue   = state_q == ISSUE;
    rdy     = op_rd_q ? rd_rdy : wr_rdy;
    state_d = state_q;
    win_d   = win_q;
    op_rd_d = op_rd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    if (!issue && lo_f) begin
      state_d = ISSUE;
      win_d   = sel;
      op_rd_d = op_rd_sel;
      addr_d  = addr_sel;
      data_d  = data_sel;
    end
    if (issue && rdy) begin
      state_d = ARB;
      last_d  = win_q;
    end
    pop         = rd_data_valid && !empty;
    err_d       = err_q || (rd_data_valid && empty);
    rsp_valid_d = pop ? (NUM_REQ'(1) << tag) : '0;
    rsp_data_d  = pop ? rd_data : '0;
  end
  assign wr_en       = issue && !op_rd_q && wr_rdy;
  assign rd_en       = issue && op_rd_q && rd_rdy;
  assign push        = rd_en;
  assign grant       = (issue && rdy) ? (NUM_REQ'(1) << win_q) : '0;
  assign grant_is_rd = issue && rdy && op_rd_q;
  assign wr_addr     = addr_q;
  assign rd_addr     = addr_q;
  assign wr_data     = data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (reset == `ASSERT_L) begin
      state_q     <= ARB;
      win_q       <= '0;
      last_q      <= TW'(NUM_REQ - 1);
      op_rd_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_q      <= last_d;
      op_rd_q     <= op_rd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end
  tag_fifo #(.W(TW), .DEPTH(RD_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (win_q),
    .full  (full),
    .empty (empty),
    .dout  (tag)
  );
endmodule

// File: tb/tb_ram_port_arb.sv
// tb_ram_port_arb: directed stimulus with queued expectations checked by a monitor
module tb_ram_port_arb;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req_wr = '0, req_rd = '0;
  logic [95:0]  req_addr = '0;
  logic [127:0] req_wr_data = '0;
  logic [3:0]   grant, rsp_valid;
  logic         grant_is_rd, wr_en, rd_en, rsp_err;
  logic [23:0]  wr_addr, rd_addr;
  logic [31:0]  wr_data, rsp_data;
  logic         wr_rdy = 1'b1, rd_rdy = 1'b1, rd_data_valid = 1'b0;
  logic [31:0]  rd_data = '0;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [3:0] g; logic rd; logic [23:0] a; logic [31:0] d; int c;} gexp_t;
  typedef struct {logic [3:0] v; logic [31:0] d; int c;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t ge;
  rexp_t re;
  ram_port_arb dut (
    .clk(clk), .reset(reset), .req_wr(req_wr), .req_rd(req_rd), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .grant(grant), .grant_is_rd(grant_is_rd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .wr_en(wr_en), .rd_en(rd_en),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_rdy(rd_rdy), .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
    $fatal(1);
  end
  always @(negedge clk) begin
    if (wr_en && rd_en) begin
      errors++;
      $display("FAIL both_en: wr_en=1 rd_en=1 at cycle %0d, required never together", cyc);
    end
    if (grant != 0 || wr_en || rd_en) begin
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: grant=%b wr_en=%b rd_en=%b at cycle %0d, required none", grant, wr_en, rd_en, cyc);
      end else begin
        ge = gq.pop_front();
        checks++;
        if (!(grant === ge.g && grant_is_rd === ge.rd && (ge.c < 0 || cyc == ge.c) &&
              (ge.rd ? (rd_en === 1'b1 && wr_en === 1'b0 && rd_addr === ge.a)
                     : (wr_en === 1'b1 && rd_en === 1'b0 && wr_addr === ge.a && wr_data === ge.d)))) begin
          errors++;
          $display("FAIL grant: got g=%b rd=%b wr_en=%b rd_en=%b wa=%h ra=%h wd=%h cyc=%0d, required g=%b rd=%b a=%h d=%h cyc=%0d",
                   grant, grant_is_rd, wr_en, rd_en, wr_addr, rd_addr, wr_data, cyc, ge.g, ge.rd, ge.a, ge.d, ge.c);
        end
      end
    end
    if (rsp_valid != 0) begin
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=%b data=%h at cycle %0d, required none", rsp_valid, rsp_data, cyc);
      end else begin
        re = rq.pop_front();
        checks++;
        if (!(rsp_valid === re.v && rsp_data === re.d && cyc == re.c)) begin
          errors++;
          $display("FAIL rsp: got v=%b d=%h cyc=%0d, required v=%b d=%h cyc=%0d", rsp_valid, rsp_data, cyc, re.v, re.d, re.c);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask
  task automatic wait_grant(input int i);
    for (int t = 0; t < 64 && !grant[i]; t++) begin
      @(posedge clk);
      #1;
    end
    if (!grant[i]) begin
      errors++;
      $display("FAIL grant_timeout: requester %0d grant=%b, required a grant", i, grant);
    end
  endtask
  task automatic set_req(input int i, input bit rd, input logic [23:0] a, input logic [31:0] d);
    req_wr[i] = !rd;
    req_rd[i] = rd;
    req_addr[i*24 +: 24] = a;
    req_wr_data[i*32 +: 32] = d;
  endtask
  task automatic do_req(input int i, input bit rd, input logic [23:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    set_req(i, rd, a, d);
    gq.push_back('{g: 4'(1) << i, rd: rd, a: a, d: d, c: cyc + 1});
    @(posedge clk);
    #1;
    wait_grant(i);
    req_wr[i] = 1'b0;
    req_rd[i] = 1'b0;
  endtask
  task automatic pulse_ret(input logic [31:0] d, input logic [3:0] v);
    @(posedge clk);
    #1;
    rd_data_valid = 1'b1;
    rd_data = d;
    rq.push_back('{v: v, d: d, c: cyc + 1});
    @(posedge clk);
    #1;
    rd_data_valid = 1'b0;
  endtask
  initial begin
    int n, c0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {grant, grant_is_rd, rsp_valid, rsp_data, wr_en, rd_en, wr_addr, rd_addr, wr_data, rsp_err}, '0);
    reset = 1'b1;
    do_req(0, 1'b0, 24'h000010, 32'hFFFFFF);
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 24'h100 + 24'(i), 32'hD0 + 32'(i));
    for (int k = 0; k < 16; k++)
      gq.push_back('{g: 4'(1) << ((1 + k) % 4), rd: 1'b0, a: 24'h100 + 24'((1 + k) % 4), d: 32'hD0 + 32'((1 + k) % 4), c: c0 + 1 + 2 * k});
    n = 0;
    for (int t = 0; t < 200 && n < 16; t++) begin
      @(posedge clk);
      #1;
      if (grant != 0) n++;
    end
    req_wr = '0;
    chk("fairness_grant_count", 128'(n), 128'd16);
    do_req(2, 1'b1, 24'h7, 32'h0);
    do_req(1, 1'b1, 24'h8, 32'h0);
    repeat (5) @(posedge clk);
    pulse_ret(32'hA, 4'b0100);
    pulse_ret(32'hB, 4'b0010);
    @(posedge clk);
    #1;
    rd_rdy = 1'b0;
    set_req(3, 1'b1, 24'h55, 32'h0);
    gq.push_back('{g: 4'b1000, rd: 1'b1, a: 24'h55, d: 32'h0, c: cyc + 11});
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("backpressure_hold", {rd_en, grant, rd_addr}, {1'b0, 4'b0000, 24'h55});
    end
    @(posedge clk);
    #1;
    rd_rdy = 1'b1;
    #1;
    req_rd[3] = 1'b0;
    pulse_ret(32'hC, 4'b1000);
    for (int k = 0; k < 8; k++) do_req(0, 1'b1, 24'h200 + 24'(k), 32'h0);
    @(posedge clk);
    #1;
    set_req(1, 1'b1, 24'h300, 32'h0);
    set_req(3, 1'b0, 24'h3F0, 32'hCAFE);
    gq.push_back('{g: 4'b1000, rd: 1'b0, a: 24'h3F0, d: 32'hCAFE, c: cyc + 1});
    @(posedge clk);
    #1;
    wait_grant(3);
    req_wr[3] = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("full_read_blocked", {28'd0, grant}, 128'd0);
    end
    req_rd[1] = 1'b0;
    for (int k = 0; k < 8; k++) pulse_ret(32'h1000 + 32'(k), 4'b0001);
    @(posedge clk);
    #1;
    rd_data_valid = 1'b1;
    rd_data = 32'hBAD;
    @(posedge clk);
    #1;
    rd_data_valid = 1'b0;
    chk("empty_return_err", {rsp_err, rsp_valid}, {1'b1, 4'b0000});
    rd_rdy = 1'b0;
    set_req(2, 1'b1, 24'h77, 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("issue_pending_addr", {104'd0, rd_addr}, {104'd0, 24'h77});
    #2;
    reset = 1'b0;
    #1;
    chk("reset_mid_issue", {grant, grant_is_rd, rsp_valid, rsp_data, wr_en, rd_en, wr_addr, rd_addr, wr_data, rsp_err}, '0);
    req_rd = '0;
    rd_rdy = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 24'hA0, 32'h11);
    set_req(1, 1'b0, 24'hA1, 32'h22);
    gq.push_back('{g: 4'b0001, rd: 1'b0, a: 24'hA0, d: 32'h11, c: cyc + 1});
    gq.push_back('{g: 4'b0010, rd: 1'b0, a: 24'hA1, d: 32'h22, c: cyc + 3});
    @(posedge clk);
    #1;
    wait_grant(0);
    req_wr[0] = 1'b0;
    @(posedge clk);
    #1;
    wait_grant(1);
    req_wr[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("grant_queue_drained", 128'(gq.size()), 128'd0);
    chk("rsp_queue_drained", 128'(rq.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
